// File: rtl/arq_pkg.sv
// Shared Stop-and-Wait ARQ definitions: FSM state encoding, default widths and
// the ACK frame layout that the transmitter also decodes.
package arq_pkg;

  localparam int unsigned DEF_SEQ_W  = 1;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    DELIVER = 2'd2,
    ACK     = 2'd3
  } state_e;

  // ACK frame on the return channel: a single cumulative Rn field.
  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
  } ack_frame_t;

  localparam int unsigned ACK_FRAME_W = $bits(ack_frame_t);

endpackage

// File: rtl/saw_receiver_if.sv
// Channel-side bundle of the SAW receiver: inbound frames, payload delivery and
// the ACK return path.
interface saw_receiver_if
  import arq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SEQ_W  = DEF_SEQ_W
);
  logic              frm_valid;
  logic              frm_ready;
  logic [SEQ_W-1:0]  frm_seq;
  logic [DATA_W-1:0] frm_data;
  logic              frm_err;
  logic              dlv_valid;
  logic              dlv_ready;
  logic [DATA_W-1:0] dlv_data;
  logic              ack_valid;
  logic              ack_ready;
  logic [SEQ_W-1:0]  ack_seq;

  modport slave (
    input  frm_valid, frm_seq, frm_data, frm_err, dlv_ready, ack_ready,
    output frm_ready, dlv_valid, dlv_data, ack_valid, ack_seq
  );

  modport master (
    output frm_valid, frm_seq, frm_data, frm_err, dlv_ready, ack_ready,
    input  frm_ready, dlv_valid, dlv_data, ack_valid, ack_seq
  );
endinterface

// File: rtl/saw_receiver_sat_counter.sv
// Saturating up-counter used for the receiver's discard statistics.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/saw_receiver.sv
// Stop-and-Wait ARQ receiver: checks each frame, delivers new in-order payloads
// and returns a cumulative ACK carrying the next expected sequence number Rn.
module saw_receiver
  import arq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SEQ_W  = DEF_SEQ_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  saw_receiver_if.slave    bus,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] dup_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  rn_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              ready_q;
  logic              dup_inc, err_inc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.frm_valid) state_d = CHECK;
      CHECK: begin
        if (err_q)              state_d = IDLE;
        else if (seq_q == rn_q) state_d = DELIVER;
        else                    state_d = ACK;
      end
      DELIVER: if (bus.dlv_ready) state_d = ACK;
      ACK:     if (bus.ack_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frm_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rn_q    <= '0;
      seq_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (state_q == IDLE && bus.frm_valid) begin
        seq_q  <= bus.frm_seq;
        data_q <= bus.frm_data;
        err_q  <= bus.frm_err;
      end
      if (state_q == DELIVER && bus.dlv_ready) begin
        rn_q <= rn_q + 1'b1;
      end
    end
  end

  assign err_inc = (state_q == CHECK) && err_q;
  assign dup_inc = (state_q == CHECK) && !err_q && (seq_q != rn_q);

  assign bus.frm_ready = ready_q;
  assign bus.dlv_valid = (state_q == DELIVER);
  assign bus.dlv_data  = (state_q == DELIVER) ? data_q : '0;
  assign bus.ack_valid = (state_q == ACK);
  assign bus.ack_seq   = (state_q == ACK) ? rn_q : '0;
  assign state         = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_dup_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dup_inc),
    .count (dup_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_saw_receiver.sv
// Directed bench for saw_receiver; a second instance with 2-bit counters mirrors
// the same stimulus to exercise counter saturation.
module tb_saw_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  saw_receiver_if #(.DATA_W(8), .SEQ_W(1)) bus ();
  saw_receiver_if #(.DATA_W(8), .SEQ_W(1)) bus_sat ();

  logic [1:0] state, state_sat;
  logic [7:0] dup_cnt, err_cnt;
  logic [1:0] dup_sat, err_sat;

  saw_receiver #(.DATA_W(8), .SEQ_W(1), .CNT_W(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state   (state),
    .dup_cnt (dup_cnt),
    .err_cnt (err_cnt)
  );

  saw_receiver #(.DATA_W(8), .SEQ_W(1), .CNT_W(2)) u_sat (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_sat),
    .state   (state_sat),
    .dup_cnt (dup_sat),
    .err_cnt (err_sat)
  );

  assign bus_sat.frm_valid = bus.frm_valid;
  assign bus_sat.frm_seq   = bus.frm_seq;
  assign bus_sat.frm_data  = bus.frm_data;
  assign bus_sat.frm_err   = bus.frm_err;
  assign bus_sat.dlv_ready = bus.dlv_ready;
  assign bus_sat.ack_ready = bus.ack_ready;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one frame in IDLE; returns in the CHECK cycle.
  task automatic send(input logic seq, input logic [7:0] data, input logic err);
    check_eq("frm_ready_idle", bus.frm_ready, 1);
    bus.frm_valid = 1'b1;
    bus.frm_seq   = seq;
    bus.frm_data  = data;
    bus.frm_err   = err;
    tick();
    bus.frm_valid = 1'b0;
    check_eq("state_check", state, 1);
    check_eq("frm_ready_check", bus.frm_ready, 0);
    check_eq("dlv_valid_check", bus.dlv_valid, 0);
  endtask

  task automatic run_good(input logic seq, input logic [7:0] data, input logic exp_ack);
    send(seq, data, 1'b0);
    tick();
    check_eq("state_deliver", state, 2);
    check_eq("dlv_valid", bus.dlv_valid, 1);
    check_eq("dlv_data", bus.dlv_data, {24'h0, data});
    tick();
    check_eq("state_ack", state, 3);
    check_eq("dlv_valid_off", bus.dlv_valid, 0);
    check_eq("ack_valid", bus.ack_valid, 1);
    check_eq("ack_seq", bus.ack_seq, {31'h0, exp_ack});
    tick();
    check_eq("state_idle", state, 0);
  endtask

  task automatic run_dup(input logic seq, input logic exp_ack);
    send(seq, 8'hEE, 1'b0);
    tick();
    check_eq("dup_state_ack", state, 3);
    check_eq("dup_no_dlv", bus.dlv_valid, 0);
    check_eq("dup_ack_valid", bus.ack_valid, 1);
    check_eq("dup_ack_seq", bus.ack_seq, {31'h0, exp_ack});
    tick();
    check_eq("dup_state_idle", state, 0);
  endtask

  task automatic run_err(input logic seq);
    send(seq, 8'h00, 1'b1);
    tick();
    check_eq("err_state_idle", state, 0);
    check_eq("err_no_dlv", bus.dlv_valid, 0);
    check_eq("err_no_ack", bus.ack_valid, 0);
  endtask

  initial begin
    bus.frm_valid = 1'b0;
    bus.frm_seq   = 1'b0;
    bus.frm_data  = 8'h00;
    bus.frm_err   = 1'b0;
    bus.dlv_ready = 1'b1;
    bus.ack_ready = 1'b1;

    // Reset state
    #2;
    check_eq("rst_state", state, 0);
    check_eq("rst_frm_ready", bus.frm_ready, 0);
    check_eq("rst_dlv_valid", bus.dlv_valid, 0);
    check_eq("rst_ack_valid", bus.ack_valid, 0);
    check_eq("rst_dup_cnt", dup_cnt, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // In-order frames
    run_good(1'b0, 8'hA5, 1'b1);
    run_good(1'b1, 8'h3C, 1'b0);
    check_eq("inorder_dup_cnt", dup_cnt, 0);
    check_eq("inorder_err_cnt", err_cnt, 0);

    // Duplicate after a lost ACK
    run_good(1'b0, 8'h11, 1'b1);
    run_dup(1'b0, 1'b1);
    check_eq("dup_cnt_1", dup_cnt, 1);

    // Corrupted frame, then the clean retransmission (Rn is 1 here)
    run_err(1'b1);
    check_eq("err_cnt_1", err_cnt, 1);
    run_good(1'b1, 8'h5A, 1'b0);

    // Backpressure on delivery then on ACK; a stray frame is ignored
    bus.dlv_ready = 1'b0;
    bus.ack_ready = 1'b0;
    send(1'b0, 8'hC3, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_dlv_valid", bus.dlv_valid, 1);
      check_eq("bp_dlv_data", bus.dlv_data, 32'hC3);
      check_eq("bp_frm_ready", bus.frm_ready, 0);
      bus.frm_valid = (i == 2);
      bus.frm_seq   = 1'b1;
      bus.frm_err   = 1'b1;
      tick();
    end
    bus.frm_valid = 1'b0;
    bus.frm_err   = 1'b0;
    bus.dlv_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_ack_valid", bus.ack_valid, 1);
      check_eq("bp_ack_seq", bus.ack_seq, 1);
      check_eq("bp_frm_ready_ack", bus.frm_ready, 0);
      tick();
    end
    bus.ack_ready = 1'b1;
    tick();
    check_eq("bp_state_idle", state, 0);
    check_eq("bp_err_cnt", err_cnt, 1);
    check_eq("bp_dup_cnt", dup_cnt, 1);

    // Saturation: six corrupted frames in total on the 2-bit instance
    for (int i = 0; i < 5; i++) run_err(1'b0);
    check_eq("err_cnt_6", err_cnt, 6);
    check_eq("sat_err_cnt", err_sat, 3);
    check_eq("sat_dup_cnt", dup_sat, 1);

    // Reset mid-DELIVER (Rn is 1 before reset)
    bus.dlv_ready = 1'b0;
    send(1'b1, 8'h77, 1'b0);
    tick();
    check_eq("pre_rst_dlv_valid", bus.dlv_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_dlv_valid", bus.dlv_valid, 0);
    check_eq("arst_dlv_data", bus.dlv_data, 0);
    check_eq("arst_state", state, 0);
    check_eq("arst_frm_ready", bus.frm_ready, 0);
    check_eq("arst_err_cnt", err_cnt, 0);
    check_eq("arst_sat_err", err_sat, 0);
    tick();
    rst = 1'b0;
    bus.dlv_ready = 1'b1;
    tick();
    run_good(1'b0, 8'h88, 1'b1);
    check_eq("post_rst_dup_cnt", dup_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
